// File: rtl/axis_load_sequencer.sv
// Channel-load sequencer: walks a channel mask in ascending order, drives a one-hot
// select to the AXIS selector and passes beat_count beats per channel, gating while the select settles.
module axis_load_sequencer #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 256,
  parameter int BEAT_W = 16,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic [BEAT_W-1:0] beat_count,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [3:0]        active_chan,
  output logic [NUM_CH-1:0] channel_select,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_STREAM = 3'd2,
    S_NEXT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q;
  logic [NUM_CH-1:0] remaining_q;
  logic [NUM_CH-1:0] channel_select_q;
  logic [BEAT_W-1:0] beat_count_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic [SET_W-1:0]  settle_cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic [3:0]        active_chan_q;

  logic              stream_s;
  logic              beat_s;
  logic              last_beat_s;
  logic              start_empty_s;
  logic [NUM_CH-1:0] remaining_d;
  logic [3:0]        first_chan_d;
  logic [3:0]        next_chan_d;

  function automatic logic [3:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_CH-1:0] one_hot(input logic [3:0] idx);
    logic [NUM_CH-1:0] v;
    v = {NUM_CH{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // The stream only flows in STREAM; every other state holds both handshake sides low
  assign stream_s      = (state_q == S_STREAM);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = stream_s & s_axis_tvalid;
  assign s_axis_tready = stream_s & m_axis_tready;
  assign beat_s        = m_axis_tvalid & m_axis_tready;
  assign last_beat_s   = beat_s & (beat_cnt_q == (beat_count_q - {{(BEAT_W-1){1'b0}}, 1'b1}));

  assign start_empty_s = (chan_mask == {NUM_CH{1'b0}}) | (beat_count == {BEAT_W{1'b0}});
  assign first_chan_d  = lowest_set(chan_mask);
  assign next_chan_d   = lowest_set(remaining_q);
  assign remaining_d   = remaining_q & ~channel_select_q;

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign active_chan    = active_chan_q;
  assign channel_select = channel_select_q;

  // Sequencer FSM with registered status and select outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      remaining_q      <= {NUM_CH{1'b0}};
      channel_select_q <= {NUM_CH{1'b0}};
      beat_count_q     <= {BEAT_W{1'b0}};
      beat_cnt_q       <= {BEAT_W{1'b0}};
      settle_cnt_q     <= {SET_W{1'b0}};
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      aborted_q        <= 1'b0;
      active_chan_q    <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort wins over a simultaneous start
          if (start && !abort) begin
            busy_q <= 1'b1;
            if (start_empty_s) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              aborted_q <= 1'b0;
            end else begin
              remaining_q      <= chan_mask;
              beat_count_q     <= beat_count;
              active_chan_q    <= first_chan_d;
              channel_select_q <= one_hot(first_chan_d);
              settle_cnt_q     <= {SET_W{1'b0}};
              state_q          <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (abort) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (settle_cnt_q == SETTLE_LAST) begin
            beat_cnt_q <= {BEAT_W{1'b0}};
            state_q    <= S_STREAM;
          end else begin
            settle_cnt_q <= settle_cnt_q + {{(SET_W-1){1'b0}}, 1'b1};
          end
        end
        S_STREAM: begin
          if (beat_s) begin
            beat_cnt_q <= beat_cnt_q + {{(BEAT_W-1){1'b0}}, 1'b1};
          end
          if (abort) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (last_beat_s) begin
            remaining_q <= remaining_d;
            state_q     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (abort) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (remaining_q == {NUM_CH{1'b0}}) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b0;
          end else begin
            active_chan_q    <= next_chan_d;
            channel_select_q <= one_hot(next_chan_d);
            settle_cnt_q     <= {SET_W{1'b0}};
            state_q          <= S_SELECT;
          end
        end
        S_DONE: begin
          state_q          <= S_IDLE;
          busy_q           <= 1'b0;
          aborted_q        <= 1'b0;
          channel_select_q <= {NUM_CH{1'b0}};
          active_chan_q    <= 4'd0;
        end
        default: begin
          state_q          <= S_IDLE;
          busy_q           <= 1'b0;
          aborted_q        <= 1'b0;
          channel_select_q <= {NUM_CH{1'b0}};
          active_chan_q    <= 4'd0;
        end
      endcase
    end
  end
endmodule
